// File: rtl/btn_cmd_encoder.sv
// rtl/btn_cmd_encoder.sv - five-button synchroniser, debouncer and press-to-command encoder
module btn_cmd_encoder #(
   parameter int DEB_CYCLES = 4,
   parameter int DEB_W      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] btn,
   input  logic       ack,
   output logic       cmd_valid,
   output logic [2:0] cmd,
   output logic [4:0] held,
   output logic       overrun
);

   localparam int NB = 5;
   // Counter value one short of the debounce period: the next mismatching edge flips the level.
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [NB-1:0]    s1;
   logic [NB-1:0]    s2;
   logic [DEB_W-1:0] cnt [NB];
   logic [NB-1:0]    flip;
   logic [NB-1:0]    rise;
   logic [NB-1:0]    pend;
   logic [NB-1:0]    take;
   logic [NB-1:0]    pend_next;
   logic             lost;
   logic             load;
   logic [2:0]       take_code;

   // Two-flop synchroniser for the asynchronous board buttons.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= btn;
         s2 <= s1;
      end
   end

   // A level flips when it has disagreed for DEB_CYCLES edges; a press is a 0->1 flip.
   always_comb begin
      flip = '0;
      for (int i = 0; i < NB; i++) begin
         flip[i] = (s2[i] != held[i]) && (cnt[i] == DEB_LAST);
      end
      rise = flip & s2;
   end

   // Per-button mismatch counters and debounced levels; any agreement restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NB; i++) begin
            cnt[i] <= '0;
         end
         held <= '0;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (s2[i] == held[i]) begin
               cnt[i] <= '0;
            end else if (flip[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
         held <= held ^ flip;
      end
   end

   // Pick the lowest pending button whenever the output register is free or being consumed.
   always_comb begin
      load      = (!cmd_valid || ack) && (pend != '0);
      take      = '0;
      take_code = '0;
      if (load) begin
         for (int i = NB - 1; i >= 0; i--) begin
            if (pend[i]) begin
               take      = NB'(1) << i;
               take_code = 3'(i + 1);
            end
         end
      end
      // A press re-arriving on a bit taken this edge survives; otherwise a duplicate is lost.
      pend_next = (pend & ~take) | rise;
      lost      = |(rise & pend & ~take);
   end

   // Pending-press mask and sticky loss flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend    <= '0;
         overrun <= 1'b0;
      end else begin
         pend <= pend_next;
         if (lost) begin
            overrun <= 1'b1;
         end
      end
   end

   // Registered command output with back-to-back reload on ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_valid <= 1'b0;
         cmd       <= '0;
      end else if (load) begin
         cmd_valid <= 1'b1;
         cmd       <= take_code;
      end else if (cmd_valid && ack) begin
         cmd_valid <= 1'b0;
         cmd       <= '0;
      end
   end

endmodule

// File: tb/tb_btn_cmd_encoder.sv
// tb/tb_btn_cmd_encoder.sv - directed self-checking bench for btn_cmd_encoder
module tb_btn_cmd_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] btn;
   logic       ack;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic [4:0] held;
   logic       overrun;

   int checks   = 0;
   int failures = 0;

   btn_cmd_encoder #(.DEB_CYCLES(4), .DEB_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (btn),
      .ack       (ack),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .held      (held),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      btn   = '0;
      ack   = 1'b0;
      tick(3);
      check("rst_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd", 32'(cmd), 32'd0);
      check("rst_held", 32'(held), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      tick(3);

      // Single press on button 2, no ack
      btn = 5'b00100;
      tick(5);
      check("t1_held_early", 32'(held), 32'd0);
      tick(1);
      check("t1_held", 32'(held), 32'b00100);
      check("t1_valid_early", 32'(cmd_valid), 32'd0);
      tick(1);
      check("t1_valid", 32'(cmd_valid), 32'd1);
      check("t1_cmd", 32'(cmd), 32'd3);
      tick(20);
      check("t1_cmd_stable", 32'(cmd), 32'd3);
      check("t1_valid_stable", 32'(cmd_valid), 32'd1);
      check("t1_overrun", 32'(overrun), 32'd0);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      check("t1_valid_ack", 32'(cmd_valid), 32'd0);
      check("t1_cmd_ack", 32'(cmd), 32'd0);
      btn = 5'b00000;
      tick(6);
      check("t1_release", 32'(held), 32'd0);
      check("t1_release_nocmd", 32'(cmd_valid), 32'd0);

      // Bounce on button 0
      for (int j = 0; j < 3; j++) begin
         btn = 5'b00001;
         tick(2);
         btn = 5'b00000;
         tick(2);
      end
      check("t2_bounce_held", 32'(held), 32'd0);
      btn = 5'b00001;
      tick(5);
      check("t2_held_early", 32'(held), 32'd0);
      tick(1);
      check("t2_held", 32'(held), 32'b00001);
      tick(1);
      check("t2_valid", 32'(cmd_valid), 32'd1);
      check("t2_cmd", 32'(cmd), 32'd1);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      tick(10);
      check("t2_single", 32'(cmd_valid), 32'd0);
      btn = 5'b00000;
      tick(8);
      check("t2_release", 32'(held), 32'd0);

      // Simultaneous presses on buttons 1 and 4 with ack tied high
      ack = 1'b1;
      btn = 5'b10010;
      tick(6);
      check("t3_held", 32'(held), 32'b10010);
      check("t3_valid_early", 32'(cmd_valid), 32'd0);
      tick(1);
      check("t3_first_valid", 32'(cmd_valid), 32'd1);
      check("t3_first_cmd", 32'(cmd), 32'd2);
      tick(1);
      check("t3_second_valid", 32'(cmd_valid), 32'd1);
      check("t3_second_cmd", 32'(cmd), 32'd5);
      tick(1);
      check("t3_idle_valid", 32'(cmd_valid), 32'd0);
      check("t3_idle_cmd", 32'(cmd), 32'd0);
      ack = 1'b0;
      btn = 5'b00000;
      tick(6);

      // Repeated presses on button 3 without ack
      btn = 5'b01000;
      tick(7);
      check("t4_cmd", 32'(cmd), 32'd4);
      btn = 5'b00000;
      tick(6);
      check("t4_release", 32'(held), 32'd0);
      btn = 5'b01000;
      tick(6);
      check("t4_repress_held", 32'(held), 32'b01000);
      check("t4_no_overrun", 32'(overrun), 32'd0);
      btn = 5'b00000;
      tick(6);
      btn = 5'b01000;
      tick(6);
      check("t4_overrun", 32'(overrun), 32'd1);
      check("t4_cmd_hold", 32'(cmd), 32'd4);
      ack = 1'b1;
      tick(1);
      check("t4_reload_valid", 32'(cmd_valid), 32'd1);
      check("t4_reload_cmd", 32'(cmd), 32'd4);
      tick(1);
      check("t4_drain_valid", 32'(cmd_valid), 32'd0);
      ack = 1'b0;
      btn = 5'b00000;
      tick(6);

      // Spurious ack, then long hold on button 1
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      check("t5_spur_valid", 32'(cmd_valid), 32'd0);
      check("t5_spur_cmd", 32'(cmd), 32'd0);
      check("t5_overrun_sticky", 32'(overrun), 32'd1);
      btn = 5'b00010;
      tick(7);
      check("t5_valid", 32'(cmd_valid), 32'd1);
      check("t5_cmd", 32'(cmd), 32'd2);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      tick(192);
      check("t5_hold_single", 32'(cmd_valid), 32'd0);
      check("t5_hold_held", 32'(held), 32'b00010);
      btn = 5'b00000;
      tick(10);
      check("t5_release_held", 32'(held), 32'd0);
      check("t5_release_nocmd", 32'(cmd_valid), 32'd0);

      // Reset in the middle of a delivery with two presses still pending
      btn = 5'b10101;
      tick(7);
      check("t6_pre_cmd", 32'(cmd), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(cmd_valid), 32'd0);
      check("t6_rst_cmd", 32'(cmd), 32'd0);
      check("t6_rst_held", 32'(held), 32'd0);
      check("t6_rst_overrun", 32'(overrun), 32'd0);
      tick(1);
      #2;
      rst_n = 1'b1;
      tick(5);
      check("t6_held_early", 32'(held), 32'd0);
      tick(1);
      check("t6_held", 32'(held), 32'b10101);
      tick(1);
      check("t6_cmd_a", 32'(cmd), 32'd1);
      ack = 1'b1;
      tick(1);
      check("t6_cmd_b", 32'(cmd), 32'd3);
      tick(1);
      check("t6_cmd_c", 32'(cmd), 32'd5);
      tick(1);
      check("t6_done", 32'(cmd_valid), 32'd0);
      ack = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
